// File: rtl/mnist_image_streamer.sv
// mnist_image_streamer
//   Feeds test images from a synchronous pattern ROM to the LGN MNIST classifier,
//   one byte per clock. It samples the classifier result a fixed latency after each
//   image and scores the result against the expected label (image number mod NUM_CLASSES).
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   start                    pulse, begins a run from image 0 (ignored while busy)
//   step_mode, step          pause after each scored image / release that pause
//   rom_addr, rom_data       ROM byte address out, read data in (one-cycle read latency)
//   pix_data, pix_valid,     byte stream towards classifier ui_in
//   pix_first
//   cls_index, cls_value     classifier winning class and score
//   res_valid, res_image,    per-image result pulse and captured fields
//   res_index, res_value,
//   res_match
//   pass_count, fail_count,  run statistics
//   first_fail, any_fail
//   busy, done               run status
module mnist_image_streamer #(
    parameter int IMAGE_COUNT     = 450,
    parameter int BYTES_PER_IMAGE = 32,
    parameter int RESULT_LATENCY  = 2,
    parameter int NUM_CLASSES     = 10,
    localparam int IMG_W          = $clog2(IMAGE_COUNT) + 1,
    localparam int BYTE_W         = $clog2(BYTES_PER_IMAGE),
    localparam int ADDR_W         = IMG_W + BYTE_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              step_mode,
    input  logic              step,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [7:0]        rom_data,
    output logic [7:0]        pix_data,
    output logic              pix_valid,
    output logic              pix_first,
    input  logic [3:0]        cls_index,
    input  logic [7:0]        cls_value,
    output logic              res_valid,
    output logic [IMG_W-1:0]  res_image,
    output logic [3:0]        res_index,
    output logic [7:0]        res_value,
    output logic              res_match,
    output logic [IMG_W-1:0]  pass_count,
    output logic [IMG_W-1:0]  fail_count,
    output logic [IMG_W-1:0]  first_fail,
    output logic              any_fail,
    output logic              busy,
    output logic              done
);

    localparam int DRAIN_W    = (RESULT_LATENCY > 2) ? $clog2(RESULT_LATENCY) : 1;
    localparam int DRAIN_LAST = (RESULT_LATENCY >= 2) ? RESULT_LATENCY - 2 : 0;

    localparam logic [BYTE_W-1:0]  BYTE_LAST  = BYTE_W'(BYTES_PER_IMAGE - 1);
    localparam logic [IMG_W-1:0]   IMG_LAST   = IMG_W'(IMAGE_COUNT - 1);
    localparam logic [3:0]         LABEL_LAST = 4'(NUM_CLASSES - 1);
    localparam logic [DRAIN_W-1:0] DRAIN_END  = DRAIN_W'(DRAIN_LAST);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_STREAM,
        S_DRAIN,
        S_CAPTURE,
        S_HOLD,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [IMG_W-1:0]   img_ptr;
    logic [BYTE_W-1:0]  byte_ptr;
    logic [BYTE_W-1:0]  byte_inc;
    logic [DRAIN_W-1:0] drain_cnt;
    logic [3:0]         label;

    logic [IMG_W-1:0]   res_image_q;
    logic [3:0]         res_index_q;
    logic [7:0]         res_value_q;
    logic               res_match_q;

    logic               match_now;
    logic               last_img;
    logic               capture;

    assign byte_inc  = byte_ptr + 1'b1;
    assign match_now = (cls_index == label);
    assign last_img  = (img_ptr == IMG_LAST);
    assign capture   = (state == S_CAPTURE);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) state_nxt = S_FETCH;
            end
            S_FETCH: begin
                state_nxt = S_STREAM;
            end
            S_STREAM: begin
                if (byte_ptr == BYTE_LAST) begin
                    state_nxt = (RESULT_LATENCY == 1) ? S_CAPTURE : S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (drain_cnt == DRAIN_END) state_nxt = S_CAPTURE;
            end
            S_CAPTURE: begin
                if (last_img)       state_nxt = S_DONE;
                else if (step_mode) state_nxt = S_HOLD;
                else                state_nxt = S_FETCH;
            end
            S_HOLD: begin
                if (step || !step_mode) state_nxt = S_FETCH;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Pointers, label tracking, result capture and scoring
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            img_ptr     <= '0;
            byte_ptr    <= '0;
            drain_cnt   <= '0;
            label       <= '0;
            res_image_q <= '0;
            res_index_q <= '0;
            res_value_q <= '0;
            res_match_q <= 1'b0;
            pass_count  <= '0;
            fail_count  <= '0;
            first_fail  <= '0;
            any_fail    <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        img_ptr    <= '0;
                        label      <= '0;
                        pass_count <= '0;
                        fail_count <= '0;
                        first_fail <= '0;
                        any_fail   <= 1'b0;
                    end
                end
                S_FETCH: begin
                    byte_ptr  <= '0;
                    drain_cnt <= '0;
                end
                S_STREAM: begin
                    byte_ptr <= byte_inc;
                end
                S_DRAIN: begin
                    drain_cnt <= drain_cnt + 1'b1;
                end
                S_CAPTURE: begin
                    res_image_q <= img_ptr;
                    res_index_q <= cls_index;
                    res_value_q <= cls_value;
                    res_match_q <= match_now;
                    if (match_now) begin
                        pass_count <= pass_count + 1'b1;
                    end else begin
                        fail_count <= fail_count + 1'b1;
                        if (!any_fail) begin
                            first_fail <= img_ptr;
                            any_fail   <= 1'b1;
                        end
                    end
                    // Label follows the image number mod NUM_CLASSES by wrap-compare.
                    if (!last_img) begin
                        img_ptr <= img_ptr + 1'b1;
                        label   <= (label == LABEL_LAST) ? '0 : label + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Datapath outputs. Result fields bypass the capture registers during CAPTURE
    // so they are valid in the same cycle as the res_valid pulse, then hold.
    always_comb begin
        pix_valid = (state == S_STREAM);
        pix_first = pix_valid && (byte_ptr == '0);
        pix_data  = pix_valid ? rom_data : 8'h00;

        rom_addr = '0;
        case (state)
            S_FETCH:  rom_addr = {img_ptr, {BYTE_W{1'b0}}};
            S_STREAM: rom_addr = {img_ptr, byte_inc};
            default:  rom_addr = '0;
        endcase

        res_valid = capture;
        res_image = capture ? img_ptr   : res_image_q;
        res_index = capture ? cls_index : res_index_q;
        res_value = capture ? cls_value : res_value_q;
        res_match = capture ? match_now : res_match_q;

        busy = (state != S_IDLE) && (state != S_DONE);
        done = (state == S_DONE);
    end

endmodule

// File: tb/tb_mnist_image_streamer.sv
// tb_mnist_image_streamer
//   Directed bench for mnist_image_streamer: a ROM model whose image i holds i[7:0]
//   in every byte, a classifier model returning i mod 10 (optionally wrong for
//   selected images), plus a second instance built with RESULT_LATENCY=1.
module tb_mnist_image_streamer;

    localparam int IMG_W  = 10;
    localparam int ADDR_W = 15;
    localparam int IMG_W2  = 3;
    localparam int ADDR_W2 = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    // Main instance (default parameters)
    logic              start = 1'b0, step_mode = 1'b0, step = 1'b0;
    logic [ADDR_W-1:0] rom_addr;
    logic [7:0]        rom_data = 8'h00;
    logic [7:0]        pix_data;
    logic              pix_valid, pix_first;
    logic [3:0]        cls_index;
    logic [7:0]        cls_value;
    logic              res_valid, res_match, any_fail, busy, done;
    logic [IMG_W-1:0]  res_image, pass_count, fail_count, first_fail;
    logic [3:0]        res_index;
    logic [7:0]        res_value;

    mnist_image_streamer #(
        .IMAGE_COUNT(450), .BYTES_PER_IMAGE(32), .RESULT_LATENCY(2), .NUM_CLASSES(10)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .step_mode(step_mode), .step(step),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .pix_data(pix_data), .pix_valid(pix_valid), .pix_first(pix_first),
        .cls_index(cls_index), .cls_value(cls_value),
        .res_valid(res_valid), .res_image(res_image), .res_index(res_index),
        .res_value(res_value), .res_match(res_match),
        .pass_count(pass_count), .fail_count(fail_count), .first_fail(first_fail),
        .any_fail(any_fail), .busy(busy), .done(done)
    );

    // Second instance: RESULT_LATENCY=1, three images, classifier always says 0
    logic               start2 = 1'b0;
    logic [ADDR_W2-1:0] rom_addr2;
    logic [7:0]         rom_data2 = 8'h00;
    logic [7:0]         pix_data2;
    logic               pix_valid2, pix_first2;
    logic               res_valid2, res_match2, any_fail2, busy2, done2;
    logic [IMG_W2-1:0]  res_image2, pass_count2, fail_count2, first_fail2;
    logic [3:0]         res_index2;
    logic [7:0]         res_value2;

    mnist_image_streamer #(
        .IMAGE_COUNT(3), .BYTES_PER_IMAGE(32), .RESULT_LATENCY(1), .NUM_CLASSES(10)
    ) dut2 (
        .clk(clk), .rst(rst), .start(start2), .step_mode(1'b0), .step(1'b0),
        .rom_addr(rom_addr2), .rom_data(rom_data2),
        .pix_data(pix_data2), .pix_valid(pix_valid2), .pix_first(pix_first2),
        .cls_index(4'd0), .cls_value(8'h00),
        .res_valid(res_valid2), .res_image(res_image2), .res_index(res_index2),
        .res_value(res_value2), .res_match(res_match2),
        .pass_count(pass_count2), .fail_count(fail_count2), .first_fail(first_fail2),
        .any_fail(any_fail2), .busy(busy2), .done(done2)
    );

    // ROM models: synchronous read
    always @(posedge clk) begin
        rom_data  <= rom_addr[12:5];
        rom_data2 <= 8'hA5;
    end

    // Classifier model: tracks which image is being streamed from pix_first
    int bad_a = -1, bad_b = -1;
    int seen = 0, cur_img = 0;

    function automatic logic [3:0] model_class(input int img);
        int c;
        c = img % 10;
        if (img == bad_a || img == bad_b) c = (c + 1) % 10;
        return 4'(c);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            seen    <= 0;
            cur_img <= 0;
        end else if (start && !busy) begin
            seen    <= 0;
            cur_img <= 0;
        end else if (pix_first) begin
            cur_img <= seen;
            seen    <= seen + 1;
        end
    end

    always_comb begin
        cls_index = model_class(cur_img);
        cls_value = 8'(cur_img) ^ 8'h5A;
    end

    int n_cmp = 0, n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    // Runs until done from the current negedge (cycle cyc0), checking every result.
    task automatic run_checked(input int cyc0, output int done_cyc, output int first_res);
        int cyc = cyc0;
        int exp_img = 0;
        first_res = -1;
        while (!done && cyc < cyc0 + 16000) begin
            if (res_valid) begin
                if (first_res < 0) first_res = cyc;
                check("res_image", res_image, exp_img);
                check("res_index", res_index, model_class(exp_img));
                check("res_value", res_value, 8'(exp_img) ^ 8'h5A);
                check("res_match", res_match,
                      (exp_img == bad_a || exp_img == bad_b) ? 0 : 1);
                exp_img++;
            end
            @(negedge clk);
            cyc++;
        end
        check("run_done", done, 1);
        check("images_scored", exp_img, 450);
        done_cyc = cyc;
    endtask

    initial begin
        int dc, fr, cyc, viol, guard;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ctrl", {pix_valid, pix_first, res_valid, busy, done, any_fail}, 0);
        check("rst_addr", rom_addr, 0);
        check("rst_counts", {pass_count, fail_count, first_fail}, 0);
        check("rst_res", {res_image, res_index, res_value, res_match}, 0);
        @(negedge clk); rst = 1'b0;

        // Run 1: first image timing in detail, then full clean run
        pulse_start();
        cyc = 1;
        check("fetch_addr", rom_addr, 0);
        check("fetch_pixv", pix_valid, 0);
        check("fetch_busy", busy, 1);
        for (int b = 0; b < 32; b++) begin
            @(negedge clk); cyc++;
            check("strm_valid", pix_valid, 1);
            check("strm_first", pix_first, (b == 0) ? 1 : 0);
            check("strm_data", pix_data, 0);
            if (b < 31) check("strm_addr", rom_addr, b + 1);
        end
        @(negedge clk); cyc++;
        check("drain_pixv", {pix_valid, pix_data}, 0);
        check("drain_res", res_valid, 0);
        @(negedge clk); cyc++;
        run_checked(cyc, dc, fr);
        check("r1_first_res_cyc", fr, 35);
        check("r1_done_cyc", dc, 15751);
        check("r1_pass", pass_count, 450);
        check("r1_fail", fail_count, 0);
        check("r1_anyfail", any_fail, 0);
        check("r1_busy", busy, 0);

        // Run 2: wrong class for images 13 and 27
        bad_a = 13; bad_b = 27;
        pulse_start();
        check("r2_done_clr", done, 0);
        run_checked(1, dc, fr);
        check("r2_first_res_cyc", fr, 35);
        check("r2_pass", pass_count, 448);
        check("r2_fail", fail_count, 2);
        check("r2_first_fail", first_fail, 13);
        check("r2_anyfail", any_fail, 1);
        bad_a = -1; bad_b = -1;

        // Run 3: step mode pause, start+step in HOLD, then reset mid image 5
        step_mode = 1'b1;
        pulse_start();
        check("r3_clr", {pass_count, fail_count, first_fail, any_fail}, 0);
        guard = 0;
        while (!res_valid && guard < 100) begin @(negedge clk); guard++; end
        check("r3_res0_seen", res_valid, 1);
        check("r3_res0_img", res_image, 0);
        viol = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!busy || pix_valid) viol++;
        end
        check("hold_quiet", viol, 0);
        check("hold_pass", pass_count, 1);
        start = 1'b1; step = 1'b1;
        @(negedge clk); start = 1'b0; step = 1'b0;
        check("step_fetch_addr", rom_addr, 32);
        check("step_fetch_pixv", pix_valid, 0);
        step_mode = 1'b0;
        @(negedge clk);
        check("step_first", pix_first, 1);
        check("step_data", pix_data, 1);
        guard = 0;
        while (!(pix_first && seen == 5) && guard < 400) begin @(negedge clk); guard++; end
        check("img5_reached", {pix_first, 8'(seen)}, {1'b1, 8'd5});
        repeat (17) @(negedge clk);
        check("b17_valid", pix_valid, 1);
        check("b17_data", pix_data, 5);
        check("b17_pass", pass_count, 5);
        rst = 1'b1;
        #1;
        check("arst_ctrl", {pix_valid, pix_first, res_valid, busy, done, any_fail}, 0);
        check("arst_data", {pix_data, rom_addr}, 0);
        check("arst_counts", {pass_count, fail_count, first_fail}, 0);
        @(negedge clk); rst = 1'b0;
        pulse_start();
        check("rs_fetch_addr", rom_addr, 0);
        @(negedge clk);
        check("rs_first", {pix_first, pix_data}, {1'b1, 8'h00});
        guard = 0;
        while (!res_valid && guard < 100) begin @(negedge clk); guard++; end
        check("rs_res_cyc", guard + 2, 35);
        check("rs_res_img", res_image, 0);
        check("rs_res_match", {res_match, res_index}, {1'b1, 4'd0});

        // RESULT_LATENCY=1 instance
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        @(negedge clk); start2 = 1'b1;
        @(negedge clk); start2 = 1'b0;
        cyc = 1;
        while (cyc < 33) begin
            @(negedge clk); cyc++;
            if (cyc == 2) check("l1_first", {pix_first2, pix_data2}, {1'b1, 8'hA5});
            start2 = (cyc == 10);
        end
        start2 = 1'b0;
        check("l1_last_byte", {pix_valid2, res_valid2}, 2'b10);
        @(negedge clk); cyc++;
        check("l1_res", {pix_valid2, res_valid2, res_image2}, {2'b01, 3'd0});
        check("l1_res_match", res_match2, 1);
        while (!done2 && cyc < 300) begin @(negedge clk); cyc++; end
        check("l1_done_cyc", cyc, 103);
        check("l1_counts", {pass_count2, fail_count2, first_fail2, any_fail2},
              {3'd1, 3'd2, 3'd1, 1'b1});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
